// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester-side and memory-side signals shared by the arbiter and its users.
// The arbiter connects through the slave modport. Bus masters and the memory connect through the master modport.
interface mem_bus_arbiter_if #(
    parameter int N = 32'sd2
);
    logic [N-1:0]   req;
    logic [N-1:0]   req_write;
    logic [N*8-1:0] req_addr;
    logic [N*8-1:0] req_wdata;
    logic [N-1:0]   ack;
    logic [N-1:0]   gnt;
    logic [7:0]     rdata;
    logic           busy;
    logic           mem_start;
    logic           mem_write;
    logic [7:0]     mem_addr;
    logic [7:0]     mem_data_out;
    logic           mem_data_oe;
    logic [7:0]     mem_data_in;

    modport slave (
        input  req, req_write, req_addr, req_wdata, mem_data_in,
        output ack, gnt, rdata, busy, mem_start, mem_write, mem_addr, mem_data_out, mem_data_oe
    );

    modport master (
        output req, req_write, req_addr, req_wdata, mem_data_in,
        input  ack, gnt, rdata, busy, mem_start, mem_write, mem_addr, mem_data_out, mem_data_oe
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one strobe-driven 8-bit memory among N requesters.
// Each transaction runs setup, strobe, hold and (for reads) a read wait, then returns a single-cycle ack.
module mem_bus_arbiter #(
    parameter int N          = 32'sd2,
    parameter int STROBE_CYC = 32'sd1,
    parameter int RD_LAT     = 32'sd1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_bus_arbiter_if.slave bus
);
    localparam int IW   = (N > 32'sd1) ? $clog2(N) : 32'sd1;
    localparam int MAXC = (STROBE_CYC > RD_LAT) ? STROBE_CYC : RD_LAT;
    localparam int CW   = $clog2(MAXC + 32'sd1);
    localparam int DW   = 32'sd8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_RDWAIT = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] win_q, win_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          start_q, start_d;
    logic          mwr_q, mwr_d;
    logic [7:0]    maddr_q, maddr_d;
    logic [7:0]    mdout_q, mdout_d;
    logic          oe_q, oe_d;
    logic          found_s;
    logic [IW-1:0] pick_s;
    logic [IW-1:0] cand_s;

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        logic [N-1:0] v;
        v      = {N{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Rotating priority search: walk from ptr+N-1 down to ptr so the closest requester after ptr wins.
    always_comb begin
        found_s = |bus.req;
        pick_s  = ptr_q;
        cand_s  = ptr_q;
        for (int i = N - 32'sd1; i >= 32'sd0; i--) begin
            cand_s = IW'((32'(ptr_q) + 32'(i)) % 32'(N));
            pick_s = bus.req[cand_s] ? cand_s : pick_s;
        end
    end

    // Next-state and next-output logic. Bus fields hold their last values unless a state overrides them.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        ack_d   = {N{1'b0}};
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        rdata_d = rdata_q;
        start_d = 1'b0;
        mwr_d   = mwr_q;
        maddr_d = maddr_q;
        mdout_d = mdout_q;
        oe_d    = oe_q;
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    state_d = S_SETUP;
                    win_d   = pick_s;
                    gnt_d   = onehot(pick_s);
                    busy_d  = 1'b1;
                    mwr_d   = bus.req_write[pick_s];
                    maddr_d = bus.req_addr[{pick_s, 3'b000} +: DW];
                    mdout_d = bus.req_wdata[{pick_s, 3'b000} +: DW];
                    oe_d    = bus.req_write[pick_s];
                end else begin
                    gnt_d  = {N{1'b0}};
                    busy_d = 1'b0;
                    oe_d   = 1'b0;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = {CW{1'b0}};
                start_d = 1'b1;
            end
            S_STROBE: begin
                if (cnt_q == CW'(STROBE_CYC - 32'sd1)) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d   = cnt_q + CW'(32'd1);
                    start_d = 1'b1;
                end
            end
            S_HOLD: begin
                oe_d = 1'b0;
                if (mwr_q) begin
                    state_d = S_DONE;
                    ack_d   = onehot(win_q);
                end else begin
                    state_d = S_RDWAIT;
                    cnt_d   = {CW{1'b0}};
                end
            end
            S_RDWAIT: begin
                // Read data arrives on the last wait cycle and is captured so it is valid with ack.
                if (cnt_q == CW'(RD_LAT - 32'sd1)) begin
                    state_d = S_DONE;
                    rdata_d = bus.mem_data_in;
                    ack_d   = onehot(win_q);
                end else begin
                    cnt_d = cnt_q + CW'(32'd1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ptr_d   = IW'((32'(win_q) + 32'd1) % 32'(N));
                gnt_d   = {N{1'b0}};
                busy_d  = 1'b0;
                oe_d    = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = {N{1'b0}};
                busy_d  = 1'b0;
                oe_d    = 1'b0;
            end
        endcase
    end

    // State, pointer and registered outputs, cleared by synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= {IW{1'b0}};
            win_q   <= {IW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            ack_q   <= {N{1'b0}};
            gnt_q   <= {N{1'b0}};
            rdata_q <= 8'h00;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            mwr_q   <= 1'b0;
            maddr_q <= 8'h00;
            mdout_q <= 8'h00;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            gnt_q   <= gnt_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            mwr_q   <= mwr_d;
            maddr_q <= maddr_d;
            mdout_q <= mdout_d;
            oe_q    <= oe_d;
        end
    end

    assign bus.ack          = ack_q;
    assign bus.gnt          = gnt_q;
    assign bus.rdata        = rdata_q;
    assign bus.busy         = busy_q;
    assign bus.mem_start    = start_q;
    assign bus.mem_write    = mwr_q;
    assign bus.mem_addr     = maddr_q;
    assign bus.mem_data_out = mdout_q;
    assign bus.mem_data_oe  = oe_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter (N=2, STROBE_CYC=1, RD_LAT=2) with a small memory model.
module tb_mem_bus_arbiter;
    localparam int N = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_clr;
    logic       start_prev;
    logic [7:0] mem [256];
    int         total = 0;
    int         bad   = 0;

    mem_bus_arbiter_if #(.N(N)) bus ();

    mem_bus_arbiter #(.N(N), .STROBE_CYC(1), .RD_LAT(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Memory model: a write is performed on the rising edge of mem_start.
    always @(posedge clk) begin
        if (mem_clr) begin
            start_prev <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= 8'hA5;
        end else begin
            start_prev <= bus.mem_start;
            if (bus.mem_start && !start_prev && bus.mem_write) mem[bus.mem_addr] <= bus.mem_data_out;
        end
    end

    assign bus.mem_data_in = bus.mem_data_oe ? 8'h00 : mem[bus.mem_addr];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int r);
        logic [N-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic wr, input logic [7:0] a, input logic [7:0] d);
        bus.req_write[r]       = wr;
        bus.req_addr[r*8 +: 8]  = a;
        bus.req_wdata[r*8 +: 8] = d;
        bus.req[r]             = 1'b1;
    endtask

    // Single transaction starting in an IDLE cycle (cycle 0); checks latency, strobe, oe and rdata.
    task automatic run_txn(input string tag, input int r, input logic wr, input logic [7:0] a,
                           input logic [7:0] d, input int exp_lat, input logic drop_early,
                           input logic [7:0] exp_rd);
        int lat = 0;
        int starts = 0;
        int start_cyc = 0;
        int oe_cnt = 0;
        set_req(r, wr, a, d);
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            tick();
            if (drop_early && c == 1) bus.req[r] = 1'b0;
            if (bus.mem_start) begin
                starts++;
                start_cyc = c;
            end
            if (bus.mem_data_oe) oe_cnt++;
            if (bus.ack != '0) begin
                lat = c;
                chk($sformatf("%s_ack", tag), 32'(bus.ack), 32'(oh(r)));
                chk($sformatf("%s_gnt", tag), 32'(bus.gnt), 32'(oh(r)));
                chk($sformatf("%s_rdata", tag), 32'(bus.rdata), 32'(exp_rd));
                chk($sformatf("%s_addr", tag), 32'(bus.mem_addr), 32'(a));
                bus.req[r] = 1'b0;
            end
        end
        chk($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat));
        chk($sformatf("%s_starts", tag), 32'(starts), 32'd1);
        chk($sformatf("%s_startcyc", tag), 32'(start_cyc), 32'd2);
        chk($sformatf("%s_oecnt", tag), 32'(oe_cnt), wr ? 32'd3 : 32'd0);
        tick();
        chk($sformatf("%s_idle", tag), 32'(bus.busy), 32'd0);
    endtask

    // Collect n acks and compare the owner order against exp_seq (2-bit index per entry).
    task automatic expect_order(input string tag, input int n, input logic [7:0] exp_seq);
        int   got = 0;
        logic after_ack = 1'b0;
        for (int c = 0; c < 30 * n && got < n; c++) begin
            tick();
            if (after_ack) chk($sformatf("%s_gap%0d", tag, got), 32'(bus.busy), 32'd0);
            after_ack = 1'b0;
            if (bus.ack != '0) begin
                chk($sformatf("%s_ack%0d", tag, got), 32'(bus.ack), 32'(oh(int'(exp_seq[2*got +: 2]))));
                chk($sformatf("%s_gnt%0d", tag, got), 32'(bus.gnt), 32'(oh(int'(exp_seq[2*got +: 2]))));
                got++;
                after_ack = 1'b1;
                if (got == n) bus.req = '0;
            end
        end
        chk($sformatf("%s_count", tag), 32'(got), 32'(n));
        tick();
        chk($sformatf("%s_idle", tag), 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        mem_clr       = 1'b1;
        bus.req       = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) tick();
        chk("rst_ack",   32'(bus.ack), 32'd0);
        chk("rst_gnt",   32'(bus.gnt), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_start", 32'(bus.mem_start), 32'd0);
        chk("rst_oe",    32'(bus.mem_data_oe), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_addr",  32'(bus.mem_addr), 32'd0);
        rst     = 1'b0;
        mem_clr = 1'b0;
        tick();

        // Test 1 and 2: write then read back
        run_txn("t1_wr", 0, 1'b1, 8'h42, 8'h5A, 4, 1'b0, 8'h00);
        chk("t1_mem", 32'(mem[8'h42]), 32'h5A);
        run_txn("t2_rd", 1, 1'b0, 8'h42, 8'h00, 6, 1'b0, 8'h5A);

        // Test 3: both requesting from reset alternate 0,1,0,1
        rst = 1'b1;
        set_req(0, 1'b1, 8'h10, 8'h01);
        set_req(1, 1'b1, 8'h20, 8'h02);
        tick();
        rst = 1'b0;
        expect_order("t3", 4, 8'h44);

        // Test 4: req1 arrives during req0 strobe; req0 stays high
        set_req(0, 1'b1, 8'h30, 8'h03);
        tick();
        tick();
        chk("t4_strobe", 32'(bus.mem_start), 32'd1);
        set_req(1, 1'b1, 8'h31, 8'h04);
        expect_order("t4", 3, 8'h04);

        // Test 5: reset in the middle of STROBE
        set_req(1, 1'b1, 8'h77, 8'h11);
        tick();
        tick();
        chk("t5_strobe", 32'(bus.mem_start), 32'd1);
        rst     = 1'b1;
        bus.req = '0;
        tick();
        chk("t5_start", 32'(bus.mem_start), 32'd0);
        chk("t5_oe",    32'(bus.mem_data_oe), 32'd0);
        chk("t5_busy",  32'(bus.busy), 32'd0);
        chk("t5_ack",   32'(bus.ack), 32'd0);
        chk("t5_gnt",   32'(bus.gnt), 32'd0);
        chk("t5_rdata", 32'(bus.rdata), 32'd0);
        rst = 1'b0;
        set_req(0, 1'b1, 8'h50, 8'h05);
        set_req(1, 1'b1, 8'h51, 8'h06);
        expect_order("t5", 1, 8'h00);

        // Test 6: address edges, early req drop
        run_txn("t6_wff", 0, 1'b1, 8'hFF, 8'hFF, 4, 1'b0, 8'h00);
        run_txn("t6_w00", 1, 1'b1, 8'h00, 8'h00, 4, 1'b1, 8'h00);
        run_txn("t6_rff", 0, 1'b0, 8'hFF, 8'h00, 6, 1'b1, 8'hFF);
        run_txn("t6_r00", 1, 1'b0, 8'h00, 8'h00, 6, 1'b0, 8'h00);
        chk("t6_memff", 32'(mem[8'hFF]), 32'hFF);
        chk("t6_mem00", 32'(mem[8'h00]), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
